// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle control unit and the MIPS datapath.
// The control unit drives the enables and selects; the datapath returns opcode, zero and mem_ready.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             halted;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted, state,
           instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted, state,
           instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// for R-type, lw, sw, beq, j and addi; stalls on mem_ready and halts on illegal opcodes.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       pc_en_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, halted_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and Moore-style control decode; only pc_en/ir_write look at inputs.
  always_comb begin
    state_d      = state_q;
    pc_en_c      = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_source_c  = 2'b00;
    halted_c     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
        else                          state_d = S_HALT;
      end
      S_MEM_READ: begin
        i_or_d_c   = 1'b1;
        mem_read_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        i_or_d_c    = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_source_c = 2'b01;
        pc_en_c     = bus.zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_c = 2'b10;
        pc_en_c     = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // An instruction retires whenever the FSM re-enters FETCH from elsewhere.
  always_comb begin
    count_d = count_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Reset overrides every output except the debug state, even within the current cycle.
  assign bus.pc_en       = pc_en_c      & ~reset;
  assign bus.i_or_d      = i_or_d_c     & ~reset;
  assign bus.mem_read    = mem_read_c   & ~reset;
  assign bus.mem_write   = mem_write_c  & ~reset;
  assign bus.ir_write    = ir_write_c   & ~reset;
  assign bus.reg_dst     = reg_dst_c    & ~reset;
  assign bus.mem_to_reg  = mem_to_reg_c & ~reset;
  assign bus.reg_write   = reg_write_c  & ~reset;
  assign bus.alu_src_a   = alu_src_a_c  & ~reset;
  assign bus.halted      = halted_c     & ~reset;
  assign bus.alu_src_b   = reset ? 2'b00 : alu_src_b_c;
  assign bus.alu_op      = reset ? 2'b00 : alu_op_c;
  assign bus.pc_source   = reset ? 2'b00 : pc_source_c;
  assign bus.state       = state_q;
  assign bus.instr_count = reset ? '0 : count_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS core. It sequences the shared datapath (PC, unified memory port, IR, register file, ALU) through fetch, decode, execute, memory and write-back for the supported subset (R-type, lw, sw, beq, j, addi). It stalls on a memory ready handshake and halts on an illegal opcode. It sits between the instruction register's opcode field and every datapath enable/mux select inside `core`.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  6  IR[31:26]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_en`  out  1  PC load enable
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  IR load enable
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = decode funct
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `halted`  out  1  FSM is in HALT
- `state`  out  4  current state encoding (debug)
- `instr_count`  out  CNT_W  retired instructions

## Operation
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000. Any other opcode is illegal.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 15.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, alu_src_b=01.
  - ir_write=1 and pc_en=1 only in a cycle with mem_ready=1; that is also the only cycle that advances to DECODE.
  - Otherwise it stays in FETCH.
- DECODE: alu_src_b=11. Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → EXECUTE
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EX
  - illegal → HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next is MEM_READ for lw, MEM_WRITE for sw. Opcode is re-sampled here; the IR is stable.
- MEM_READ: i_or_d=1, mem_read=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, then FETCH.
- MEM_WRITE: i_or_d=1, mem_write=1. Holds until mem_ready, then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_op=10, then ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, then FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_en=zero (combinational), then FETCH.
- JUMP: pc_source=10, pc_en=1, then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, then ADDI_WB.
- ADDI_WB: reg_write=1, then FETCH.
- HALT: all control outputs 0, halted=1. Stays until reset.
- instr_count:
  - Increments by 1 on each transition into FETCH from a non-FETCH state (instruction retired).
  - Wraps modulo 2^CNT_W.
  - Never increments on entry to HALT.

## Timing
- Reset is asynchronous: state goes to FETCH and instr_count to 0 immediately.
- While reset=1, every output except `state` is forced to 0, including mem_read.
- The first fetch request is in the first cycle after reset deasserts.
- All outputs are decoded from the registered state. Only pc_en (FETCH/mem_ready, BRANCH/zero) and ir_write (FETCH/mem_ready) depend combinationally on inputs.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Request signals hold steady during the stall.
- mem_ready is ignored in every other state.
- Reset asserted mid-instruction (for example in MEM_WRITE) drops mem_write in the same cycle, combinationally. No retirement is counted.

## Test plan
- Reset with mem_ready=1: hold reset 2 cycles → all outputs 0, state=0. First cycle after release: mem_read=1, ir_write=1, pc_en=1.
- Sequence R, lw, sw, addi, beq, j, with mem_ready=1:
  - State traces are 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,10,11 / 0,1,8 / 0,1,9.
  - instr_count=6 afterwards.
- beq in BRANCH with zero=0 → pc_en=0. Repeat with zero=1 → pc_en=1, pc_source=01.
- lw with mem_ready held 0 for 3 cycles in MEM_READ:
  - Stays in state 3 with i_or_d=1, mem_read=1 for 4 cycles total.
  - Then MEM_WB with reg_write=1, mem_to_reg=1.
- opcode=111111 at DECODE:
  - Enters state 15 with halted=1.
  - Stays there 10 cycles with mem_ready toggling; instr_count unchanged.
  - Reset releases to FETCH.
- CNT_W=4: retire 17 j instructions → instr_count=1 (wrap verified).
